// File: rtl/axi5_rd_cg_ctrl_mc.sv
// Multi-channel clock-gate controller for AXI5 read ports: per-channel outstanding
// tracking, idle timeout, gated/wake sequencing, ICG enable and ready-block mask.
module axi5_rd_cg_ctrl_mc #(
  parameter int NUM_CH              = 4,
  parameter int CG_IDLE_COUNT_WIDTH = 4,
  parameter int OTS_WIDTH           = 6,
  parameter int WAKE_CYCLES         = 2
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_CH-1:0]              cfg_cg_enable,
  input  logic [CG_IDLE_COUNT_WIDTH-1:0] cfg_cg_idle_count,
  input  logic [NUM_CH-1:0]              ch_arvalid,
  input  logic [NUM_CH-1:0]              ch_arready,
  input  logic [NUM_CH-1:0]              ch_rvalid,
  input  logic [NUM_CH-1:0]              ch_rready,
  input  logic [NUM_CH-1:0]              ch_rlast,
  input  logic [NUM_CH-1:0]              ch_busy,
  output logic [NUM_CH-1:0]              cg_clk_en,
  output logic [NUM_CH-1:0]              cg_block,
  output logic [NUM_CH-1:0]              cg_gating,
  output logic [NUM_CH-1:0]              cg_idle,
  output logic                           cg_all_gated,
  output logic [NUM_CH*OTS_WIDTH-1:0]    ots_count,
  output logic [NUM_CH-1:0]              err_ots_ovf,
  output logic [NUM_CH-1:0]              err_ots_udf
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_GATED  = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;

  localparam logic [OTS_WIDTH-1:0]           OTS_MAX   = '1;
  localparam logic [CG_IDLE_COUNT_WIDTH-1:0] IDLE_MAX  = '1;
  localparam logic [3:0]                     WAKE_LOAD = 4'(WAKE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]                     state_reg, state_next;
      logic [CG_IDLE_COUNT_WIDTH-1:0] idle_cnt_reg, idle_cnt_next;
      logic [3:0]                     wake_cnt_reg, wake_cnt_next;
      logic [OTS_WIDTH-1:0]           ots_reg, ots_next;
      logic                           ovf_reg, ovf_next;
      logic                           udf_reg, udf_next;
      logic                           clk_en_reg, gating_reg, hold_block_reg;
      logic                           ar_hs, rl_hs, activity, wake_req, gate_now;

      assign ar_hs    = ch_arvalid[gi] & ch_arready[gi];
      assign rl_hs    = ch_rvalid[gi] & ch_rready[gi] & ch_rlast[gi];
      assign activity = ch_arvalid[gi] | ch_rvalid[gi] | ch_busy[gi] | (ots_reg != '0);
      assign wake_req = ch_arvalid[gi] | ch_rvalid[gi] | ch_busy[gi] | ~cfg_cg_enable[gi];

      // Gating decision is visible combinationally so ready is masked on the
      // same cycle the FSM commits to stopping the clock.
      assign gate_now = (state_reg == ST_ACTIVE) & ~activity & cfg_cg_enable[gi] &
                        (idle_cnt_reg >= cfg_cg_idle_count) & ~areset;

      always_comb begin
        ots_next = ots_reg;
        ovf_next = ovf_reg;
        udf_next = udf_reg;
        if (ar_hs && !rl_hs) begin
          if (ots_reg == OTS_MAX) ovf_next = 1'b1;
          else                    ots_next = ots_reg + OTS_WIDTH'(1);
        end else if (rl_hs && !ar_hs) begin
          if (ots_reg == '0) udf_next = 1'b1;
          else               ots_next = ots_reg - OTS_WIDTH'(1);
        end
      end

      always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        wake_cnt_next = wake_cnt_reg;
        case (state_reg)
          ST_ACTIVE: begin
            if (activity || !cfg_cg_enable[gi]) begin
              idle_cnt_next = '0;
            end else if (idle_cnt_reg >= cfg_cg_idle_count) begin
              state_next = ST_GATED;
            end else if (idle_cnt_reg != IDLE_MAX) begin
              idle_cnt_next = idle_cnt_reg + CG_IDLE_COUNT_WIDTH'(1);
            end
          end
          ST_GATED: begin
            if (wake_req) begin
              state_next    = ST_WAKE;
              wake_cnt_next = WAKE_LOAD;
            end
          end
          ST_WAKE: begin
            // Wake always runs to completion, even if the requester goes quiet.
            if (wake_cnt_reg == 4'd0) begin
              state_next    = ST_ACTIVE;
              idle_cnt_next = '0;
            end else begin
              wake_cnt_next = wake_cnt_reg - 4'd1;
            end
          end
          default: begin
            state_next    = ST_ACTIVE;
            idle_cnt_next = '0;
          end
        endcase
      end

      always_ff @(posedge aclk) begin
        if (areset) begin
          state_reg      <= ST_ACTIVE;
          idle_cnt_reg   <= '0;
          wake_cnt_reg   <= '0;
          ots_reg        <= '0;
          ovf_reg        <= 1'b0;
          udf_reg        <= 1'b0;
          clk_en_reg     <= 1'b1;
          gating_reg     <= 1'b0;
          hold_block_reg <= 1'b0;
        end else begin
          state_reg      <= state_next;
          idle_cnt_reg   <= idle_cnt_next;
          wake_cnt_reg   <= wake_cnt_next;
          ots_reg        <= ots_next;
          ovf_reg        <= ovf_next;
          udf_reg        <= udf_next;
          clk_en_reg     <= (state_next != ST_GATED);
          gating_reg     <= (state_next == ST_GATED);
          hold_block_reg <= (state_next != ST_ACTIVE);
        end
      end

      assign cg_clk_en[gi]                          = clk_en_reg;
      assign cg_block[gi]                           = hold_block_reg | gate_now;
      assign cg_gating[gi]                          = gating_reg;
      assign cg_idle[gi]                            = ~activity;
      assign ots_count[gi*OTS_WIDTH +: OTS_WIDTH]   = ots_reg;
      assign err_ots_ovf[gi]                        = ovf_reg;
      assign err_ots_udf[gi]                        = udf_reg;
    end
  endgenerate

  assign cg_all_gated = &cg_gating;

endmodule

// File: tb/tb_axi5_rd_cg_ctrl_mc.sv
// Bench for axi5_rd_cg_ctrl_mc: per-cycle vector table plus hand-written
// wake, all-gated and reset-during-wake sequences.
module tb_axi5_rd_cg_ctrl_mc;

  localparam int NUM_CH = 4;
  localparam int CGW    = 4;
  localparam int OTSW   = 2;
  localparam int WAKE   = 2;

  logic                   aclk = 1'b0;
  logic                   areset;
  logic [NUM_CH-1:0]      cfg_cg_enable;
  logic [CGW-1:0]         cfg_cg_idle_count;
  logic [NUM_CH-1:0]      ch_arvalid, ch_arready, ch_rvalid, ch_rready, ch_rlast, ch_busy;
  logic [NUM_CH-1:0]      cg_clk_en, cg_block, cg_gating, cg_idle;
  logic                   cg_all_gated;
  logic [NUM_CH*OTSW-1:0] ots_count;
  logic [NUM_CH-1:0]      err_ots_ovf, err_ots_udf;

  int n_checks = 0;
  int n_err    = 0;

  always #5 aclk = ~aclk;

  axi5_rd_cg_ctrl_mc #(
    .NUM_CH(NUM_CH), .CG_IDLE_COUNT_WIDTH(CGW), .OTS_WIDTH(OTSW), .WAKE_CYCLES(WAKE)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_cg_enable(cfg_cg_enable), .cfg_cg_idle_count(cfg_cg_idle_count),
    .ch_arvalid(ch_arvalid), .ch_arready(ch_arready),
    .ch_rvalid(ch_rvalid), .ch_rready(ch_rready), .ch_rlast(ch_rlast), .ch_busy(ch_busy),
    .cg_clk_en(cg_clk_en), .cg_block(cg_block), .cg_gating(cg_gating), .cg_idle(cg_idle),
    .cg_all_gated(cg_all_gated), .ots_count(ots_count),
    .err_ots_ovf(err_ots_ovf), .err_ots_udf(err_ots_udf)
  );

  typedef struct {
    logic       rst;
    logic [3:0] en, arv, arr, rv, rr, rl, busy;
    logic [3:0] x_clk_en, x_block, x_gating, x_idle;
    logic [7:0] x_ots;
    logic [3:0] x_ovf, x_udf;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic quiet();
    ch_arvalid = '0; ch_arready = '0;
    ch_rvalid  = '0; ch_rready  = '0; ch_rlast = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Threshold 3. ch0 takes an R-last at count 0 then idles into GATED,
    // ch1 stays busy, ch2 runs AR/R-last counting, ch3 overflows its 2-bit counter.
    //           rst  en    arv   arr   rv    rr    rl    busy  clk_en blk  gat   idle  ots    ovf   udf
    vec[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 8'h00, 4'h0, 4'h0};
    vec[1]  = '{1'b0, 4'hF, 4'hC, 4'hC, 4'h1, 4'h1, 4'h1, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0};
    vec[2]  = '{1'b0, 4'hF, 4'hC, 4'hC, 4'h0, 4'h0, 4'h0, 4'h2, 4'hF, 4'h0, 4'h0, 4'h1, 8'h50, 4'h0, 4'h1};
    vec[3]  = '{1'b0, 4'hF, 4'hC, 4'hC, 4'h0, 4'h0, 4'h0, 4'h2, 4'hF, 4'h0, 4'h0, 4'h1, 8'hA0, 4'h0, 4'h1};
    vec[4]  = '{1'b0, 4'hF, 4'hC, 4'hC, 4'h4, 4'h4, 4'h4, 4'h2, 4'hF, 4'h0, 4'h0, 4'h1, 8'hF0, 4'h0, 4'h1};
    vec[5]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hF, 4'h1, 4'h0, 4'h1, 8'hF0, 4'h8, 4'h1};
    vec[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hF0, 4'h8, 4'h1};
    vec[7]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hF0, 4'h8, 4'h1};
    vec[8]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hF0, 4'h8, 4'h1};
    vec[9]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hF0, 4'h8, 4'h1};
    vec[10] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hF0, 4'h8, 4'h1};
    vec[11] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hE0, 4'h8, 4'h1};
    vec[12] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h2, 4'hE, 4'h1, 4'h1, 4'h1, 8'hD0, 4'h8, 4'h1};
    vec[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hE, 4'h1, 4'h1, 4'h5, 8'hC0, 4'h8, 4'h1};

    areset = 1'b1; cfg_cg_enable = 4'hF; cfg_cg_idle_count = 4'd3; ch_busy = '0;
    quiet();
    repeat (2) @(negedge aclk);

    // Inputs change at the falling edge; outputs are sampled 1 ns before the rising edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge aclk);
      areset = vec[i].rst; cfg_cg_enable = vec[i].en;
      ch_arvalid = vec[i].arv; ch_arready = vec[i].arr;
      ch_rvalid = vec[i].rv; ch_rready = vec[i].rr; ch_rlast = vec[i].rl;
      ch_busy = vec[i].busy;
      #4;
      chk($sformatf("v%0d clk_en", i), {4'h0, cg_clk_en},   {4'h0, vec[i].x_clk_en});
      chk($sformatf("v%0d block",  i), {4'h0, cg_block},    {4'h0, vec[i].x_block});
      chk($sformatf("v%0d gating", i), {4'h0, cg_gating},   {4'h0, vec[i].x_gating});
      chk($sformatf("v%0d idle",   i), {4'h0, cg_idle},     {4'h0, vec[i].x_idle});
      chk($sformatf("v%0d ots",    i), ots_count,           vec[i].x_ots);
      chk($sformatf("v%0d ovf",    i), {4'h0, err_ots_ovf}, {4'h0, vec[i].x_ovf});
      chk($sformatf("v%0d udf",    i), {4'h0, err_ots_udf}, {4'h0, vec[i].x_udf});
    end

    // All channels idle from reset: decision on cycle 4, all gated on cycle 5.
    @(negedge aclk); areset = 1'b1; quiet(); ch_busy = '0; cfg_cg_enable = 4'hF;
    @(negedge aclk);
    @(negedge aclk); areset = 1'b0;
    #4 chk("c1 block", {4'h0, cg_block}, 8'h00);
    repeat (3) @(negedge aclk);
    #4;
    chk("c4 block", {4'h0, cg_block}, 8'h0F);
    chk("c4 all_gated", {7'h0, cg_all_gated}, 8'h00);
    @(negedge aclk); #4;
    chk("c5 all_gated", {7'h0, cg_all_gated}, 8'h01);
    chk("c5 clk_en", {4'h0, cg_clk_en}, 8'h00);

    // Disabling ch2 wakes it; the wake completes even though enable returns.
    @(negedge aclk); cfg_cg_enable = 4'b1011;
    #4 chk("c6 all_gated", {7'h0, cg_all_gated}, 8'h01);
    @(negedge aclk); cfg_cg_enable = 4'hF;
    #4;
    chk("c7 all_gated", {7'h0, cg_all_gated}, 8'h00);
    chk("c7 gating", {4'h0, cg_gating}, 8'h0B);
    chk("c7 clk_en", {4'h0, cg_clk_en}, 8'h04);
    chk("c7 block", {4'h0, cg_block}, 8'h0F);
    @(negedge aclk); #4 chk("c8 clk_en", {4'h0, cg_clk_en}, 8'h04);
    @(negedge aclk); #4 chk("c9 block", {4'h0, cg_block}, 8'h0B);

    // ch1 wake latency: arvalid at T, clock at T+1, ready unblocked at T+3.
    @(negedge aclk); ch_arvalid = 4'b0010;
    #4;
    chk("T clk_en", {4'h0, cg_clk_en}, 8'h04);
    chk("T idle", {4'h0, cg_idle}, 8'h0D);
    @(negedge aclk); #4;
    chk("T+1 clk_en", {4'h0, cg_clk_en}, 8'h06);
    chk("T+1 block", {4'h0, cg_block}, 8'h0B);
    chk("T+1 gating", {4'h0, cg_gating}, 8'h09);
    @(negedge aclk); #4 chk("T+2 block1", {7'h0, cg_block[1]}, 8'h01);
    @(negedge aclk); ch_arready = 4'b0010;
    #4;
    chk("T+3 block1", {7'h0, cg_block[1]}, 8'h00);
    chk("T+3 clk_en", {4'h0, cg_clk_en}, 8'h02);
    @(negedge aclk); quiet(); ch_rvalid = 4'b1010; ch_rready = 4'b1010; ch_rlast = 4'b1010;
    #4 chk("T+4 ots", ots_count, 8'h04);
    @(negedge aclk); quiet();
    #4;
    chk("T+5 udf", {4'h0, err_ots_udf}, 8'h08);
    chk("T+5 ots", ots_count, 8'h00);

    // Re-gate ch1 (bounded wait), then force handshakes while blocked and reset mid-wake.
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge aclk); #4;
        if (cg_gating[1]) seen = 1'b1;
      end
      chk("ch1 regate", {7'h0, seen}, 8'h01);
    end
    @(negedge aclk); ch_arvalid = 4'b0010; ch_arready = 4'b0010;
    #4 chk("G+1 gating1", {7'h0, cg_gating[1]}, 8'h01);
    @(negedge aclk); #4 chk("G+2 ots", ots_count, 8'h04);
    @(negedge aclk); quiet(); areset = 1'b1;
    #4;
    chk("G+3 ots", ots_count, 8'h08);
    chk("G+3 wake", {5'h0, cg_block[1], cg_clk_en[1], cg_gating[1]}, 8'h06);
    @(negedge aclk); areset = 1'b0;
    #4;
    chk("rst clk_en", {4'h0, cg_clk_en}, 8'h0F);
    chk("rst block", {4'h0, cg_block}, 8'h00);
    chk("rst gating", {4'h0, cg_gating}, 8'h00);
    chk("rst all_gated", {7'h0, cg_all_gated}, 8'h00);
    chk("rst ots", ots_count, 8'h00);
    chk("rst errs", {err_ots_ovf, err_ots_udf}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axi5_rd_cg_ctrl_mc.md
Name: axi5_rd_cg_ctrl_mc

Overview:
Multi-channel clock-gate controller for AXI5 read paths. It generalises the single-instance gating wrapper to NUM_CH independent read ports. Each channel tracks outstanding AR→R-last transactions, idle time, and a wake sequence, and drives its own ICG enable and ready-block mask. It sits beside N axi5_master_rd instances in a multi-port read fabric and never gates a channel with reads in flight.

Parameters:
NUM_CH, 4, number of independent read channels (1..16)
CG_IDLE_COUNT_WIDTH, 4, width of the idle-count threshold
OTS_WIDTH, 6, width of the per-channel outstanding counter (max 2^OTS_WIDTH-1)
WAKE_CYCLES, 2, cycles the clock is enabled with ready still blocked before the channel resumes (1..15)

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
cfg_cg_enable  in  NUM_CH  per-channel gating enable
cfg_cg_idle_count  in  CG_IDLE_COUNT_WIDTH  idle cycles required before gating (shared)
ch_arvalid  in  NUM_CH  AR valid per channel (fub side)
ch_arready  in  NUM_CH  AR ready as seen by the fub (post-mask)
ch_rvalid  in  NUM_CH  R valid per channel (m side)
ch_rready  in  NUM_CH  R ready as seen by m side (post-mask)
ch_rlast  in  NUM_CH  R last per channel
ch_busy  in  NUM_CH  internal busy from the base read module
cg_clk_en  out  NUM_CH  enable to the external ICG cell per channel
cg_block  out  NUM_CH  force-low mask for arready/rready
cg_gating  out  NUM_CH  channel is in GATED
cg_idle  out  NUM_CH  channel has no activity this cycle and outstanding==0
cg_all_gated  out  1  AND of cg_gating
ots_count  out  NUM_CH*OTS_WIDTH  per-channel outstanding count, channel 0 in LSBs
err_ots_ovf  out  NUM_CH  sticky: AR accepted at max count
err_ots_udf  out  NUM_CH  sticky: R-last accepted at count 0

Behaviour:
- Reset (areset=1 at a rising aclk edge): all channels go to ACTIVE; cg_clk_en=all 1, cg_block=0, cg_gating=0, cg_all_gated=0, ots_count=0, idle counters=0, err flags=0. cg_idle is combinational, so it reads 1 during reset when the inputs are quiet.
- Events per channel: ar_hs = arvalid&arready; rl_hs = rvalid&rready&rlast.
- Outstanding count:
  - ar_hs only: +1.
  - rl_hs only: -1.
  - Both in the same cycle: unchanged.
  - ar_hs only at max: hold the count, set err_ots_ovf.
  - rl_hs only at 0: hold at 0, set err_ots_udf.
  - Error flags clear only on reset.
- activity = arvalid | rvalid | busy | (ots!=0). cg_idle = ~activity.
- Per-channel FSM, all registered outputs:
  - ACTIVE:
    - activity or ~cfg_cg_enable: clear the idle counter.
    - Otherwise, if idle_cnt >= cfg_cg_idle_count: go to GATED.
    - Otherwise: idle_cnt +1, saturating.
    - Threshold 0 means the first idle cycle gates; cg_clk_en falls on the next edge.
  - GATED: cg_clk_en=0, cg_block=1, cg_gating=1.
    - arvalid | rvalid | busy, or ~cfg_cg_enable: go to WAKE and load wake_cnt=WAKE_CYCLES-1.
  - WAKE: cg_clk_en=1, cg_block=1, cg_gating=0.
    - Decrement wake_cnt; at 0 go to ACTIVE with idle_cnt=0.
    - Activity dropping during WAKE does not abort the wake.
  - Resulting latency: a gated channel accepts AR no earlier than WAKE_CYCLES+1 cycles after arvalid rises.
- cg_block is also 1 in the ACTIVE cycle of the gating decision. Ready masking therefore precedes clock stop, so no handshake lands on the gating edge.
- Handshakes reported while cg_block=1 are a protocol fault. Counting still applies; no extra flag.
- Channels are fully independent; no shared arbitration.
- cfg_cg_idle_count may change at any time and takes effect on the next comparison.

Test Plan:
- NUM_CH=4, threshold=3, ch0 quiet with enable=1 → cg_block[0]=1 after 4 idle cycles, cg_clk_en[0]=0 and cg_gating[0]=1 the next cycle; other channels unaffected.
- ch1 gated, arvalid[1] raised at cycle T, WAKE_CYCLES=2 → cg_clk_en[1]=1 at T+1, cg_block[1]=0 at T+3, ACTIVE at T+3.
- ch2: 3 AR handshakes, then a same-cycle AR and R-last, then 3 R-lasts → ots_count goes 3,3,0; channel never gates while ots≠0 even with all valids low.
- OTS_WIDTH=2, 4 AR handshakes with no R → count saturates at 3, err_ots_ovf[3]=1; R-last at 0 on ch0 → err_ots_udf[0]=1, count stays 0.
- All channels gated → cg_all_gated=1; deassert cfg_cg_enable[2] → ch2 goes to WAKE, cg_all_gated=0 next cycle.
- areset pulsed while ch1 is in WAKE with ots=2 → next cycle all ACTIVE, cg_clk_en=4'hF, ots_count=0, errs=0.
